// File: rtl/rs_entry_array.sv
// Reservation-station entry array: dispatch allocation, CDB operand wakeup, ready requests and issue.
// Define RS_ISSUE_REG_EN to register the issue packets (1-cycle grant-to-issue latency).
`ifndef CAL_IDX_LEN
`define CAL_IDX_LEN(n) (((n) > 1) ? $clog2(n) : 1)
`endif

module rs_entry_array #(
  parameter  int Q_SIZE      = 32,
  parameter  int S_SIZE      = 3,
  parameter  int D_SIZE      = 3,
  parameter  int CDB_SIZE    = 3,
  parameter  int TAG_LEN     = 6,
  parameter  int PAYLOAD_LEN = 64,
  localparam int INDEX_LEN   = `CAL_IDX_LEN(Q_SIZE)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [D_SIZE-1:0]                     dispatch_valid,
  input  logic [D_SIZE-1:0][TAG_LEN-1:0]        dispatch_tag1,
  input  logic [D_SIZE-1:0][TAG_LEN-1:0]        dispatch_tag2,
  input  logic [D_SIZE-1:0]                     dispatch_rdy1,
  input  logic [D_SIZE-1:0]                     dispatch_rdy2,
  input  logic [D_SIZE-1:0][PAYLOAD_LEN-1:0]    dispatch_payload,
  input  logic [CDB_SIZE-1:0]                   cdb_valid,
  input  logic [CDB_SIZE-1:0][TAG_LEN-1:0]      cdb_tag,
  output logic [Q_SIZE-1:0]                     request,
  input  logic [S_SIZE-1:0][INDEX_LEN-1:0]      select,
  input  logic [S_SIZE-1:0]                     select_valid,
  output logic [S_SIZE-1:0]                     issue_valid,
  output logic [S_SIZE-1:0][PAYLOAD_LEN-1:0]    issue_payload,
  output logic [INDEX_LEN:0]                    free_count,
  output logic                                  full
);

  logic [Q_SIZE-1:0]      valid_q, valid_d;
  logic [Q_SIZE-1:0]      rdy1_q, rdy1_d;
  logic [Q_SIZE-1:0]      rdy2_q, rdy2_d;
  logic [TAG_LEN-1:0]     tag1_q    [Q_SIZE];
  logic [TAG_LEN-1:0]     tag2_q    [Q_SIZE];
  logic [PAYLOAD_LEN-1:0] payload_q [Q_SIZE];

  logic [D_SIZE-1:0]                lane_alloc;
  logic [D_SIZE-1:0][INDEX_LEN-1:0] lane_idx;
  logic [D_SIZE-1:0]                lane_rdy1, lane_rdy2;
  logic [Q_SIZE-1:0]                avail;
  logic [S_SIZE-1:0][PAYLOAD_LEN-1:0] sel_payload;

  function automatic logic cdb_hit(input logic [CDB_SIZE-1:0]              cv,
                                   input logic [CDB_SIZE-1:0][TAG_LEN-1:0] ct,
                                   input logic [TAG_LEN-1:0]               t);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_SIZE; c++) begin
      if (cv[c] && (ct[c] == t)) cdb_hit = 1'b1;
    end
  endfunction

  // Selector handshake: request is a pure function of registered state; the selector
  // answers with select/select_valid in the same cycle and the granted entry frees at the edge.
  assign request = valid_q & rdy1_q & rdy2_q;

  always_comb begin
    free_count = '0;
    for (int i = 0; i < Q_SIZE; i++) begin
      free_count = free_count + {{INDEX_LEN{1'b0}}, ~valid_q[i]};
    end
  end

  assign full = (free_count < (INDEX_LEN + 1)'(D_SIZE));

  // Lanes take the lowest free entries in lane order; a lane with nothing left is dropped.
  always_comb begin
    avail      = ~valid_q;
    lane_alloc = '0;
    lane_idx   = '0;
    lane_rdy1  = '0;
    lane_rdy2  = '0;
    for (int d = 0; d < D_SIZE; d++) begin
      lane_rdy1[d] = dispatch_rdy1[d] | cdb_hit(cdb_valid, cdb_tag, dispatch_tag1[d]);
      lane_rdy2[d] = dispatch_rdy2[d] | cdb_hit(cdb_valid, cdb_tag, dispatch_tag2[d]);
      if (dispatch_valid[d]) begin
        for (int i = Q_SIZE - 1; i >= 0; i--) begin
          if (avail[i]) begin
            lane_alloc[d] = 1'b1;
            lane_idx[d]   = INDEX_LEN'(i);
          end
        end
        if (lane_alloc[d]) avail[lane_idx[d]] = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    for (int i = 0; i < Q_SIZE; i++) begin
      if (valid_q[i] && cdb_hit(cdb_valid, cdb_tag, tag1_q[i])) rdy1_d[i] = 1'b1;
      if (valid_q[i] && cdb_hit(cdb_valid, cdb_tag, tag2_q[i])) rdy2_d[i] = 1'b1;
    end
    for (int k = 0; k < S_SIZE; k++) begin
      if (select_valid[k]) valid_d[select[k]] = 1'b0;
    end
    for (int d = 0; d < D_SIZE; d++) begin
      if (lane_alloc[d]) begin
        valid_d[lane_idx[d]] = 1'b1;
        rdy1_d[lane_idx[d]]  = lane_rdy1[d];
        rdy2_d[lane_idx[d]]  = lane_rdy2[d];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
    end
  end

  // Tags and payloads are meaningless while an entry is invalid, so they carry no reset.
  always_ff @(posedge clock) begin
    for (int d = 0; d < D_SIZE; d++) begin
      if (lane_alloc[d]) begin
        tag1_q[lane_idx[d]]    <= dispatch_tag1[d];
        tag2_q[lane_idx[d]]    <= dispatch_tag2[d];
        payload_q[lane_idx[d]] <= dispatch_payload[d];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < S_SIZE; k++) begin
      sel_payload[k] = payload_q[select[k]];
    end
  end

`ifdef RS_ISSUE_REG_EN
  logic [S_SIZE-1:0]                  issue_valid_q;
  logic [S_SIZE-1:0][PAYLOAD_LEN-1:0] issue_payload_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_valid_q   <= '0;
      issue_payload_q <= '0;
    end else if (flush) begin
      issue_valid_q   <= '0;
      issue_payload_q <= '0;
    end else begin
      issue_valid_q   <= select_valid;
      issue_payload_q <= sel_payload;
    end
  end

  assign issue_valid   = issue_valid_q;
  assign issue_payload = issue_payload_q;
`else
  assign issue_valid   = select_valid;
  assign issue_payload = sel_payload;
`endif

endmodule
